instr_sequencer: RTL and testbench

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/seq_pkg.sv | 27 ++
 rtl/instr_decoder.sv | 34 +++
 rtl/instr_sequencer.sv | 146 ++++++++++++++
 tb/tb_instr_sequencer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared types and constants for the instruction sequencer: FSM states,
// opcode values, instruction field positions and register-address width.
package seq_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    READ   = 3'd3,
    EXEC   = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6
  } state_t;

  localparam int RA_W  = 3;
  localparam int OPC_W = 4;

  localparam logic [OPC_W-1:0] OP_NOP  = 4'h0;
  localparam logic [OPC_W-1:0] OP_HALT = 4'hF;

  // Field LSB positions; the low three bits below RS2 carry nothing.
  localparam int OPC_LSB = 12;
  localparam int RD_LSB  = 9;
  localparam int RS1_LSB = 6;
  localparam int RS2_LSB = 3;

endpackage

// File: rtl/instr_decoder.sv
// Combinational instruction decoder: splits IR into register fields and
// classifies the opcode as NOP, HALT, ALU (0x1..0x7) or illegal (0x8..0xE).
module instr_decoder
  import seq_pkg::*;
#(
  parameter int IR_W = 16
) (
  input  logic [IR_W-1:0] ir,
  output logic [RA_W-1:0] rd,
  output logic [RA_W-1:0] rs1,
  output logic [RA_W-1:0] rs2,
  output logic [2:0]      alu_op,
  output logic            is_nop,
  output logic            is_halt,
  output logic            is_alu,
  output logic            is_illegal
);

  logic [OPC_W-1:0] opcode;
  logic             unused_low;

  assign opcode     = ir[OPC_LSB +: OPC_W];
  assign rd         = ir[RD_LSB +: RA_W];
  assign rs1        = ir[RS1_LSB +: RA_W];
  assign rs2        = ir[RS2_LSB +: RA_W];
  assign alu_op     = opcode[2:0];
  assign unused_low = ^ir[RS2_LSB-1:0];

  assign is_nop     = (opcode == OP_NOP);
  assign is_halt    = (opcode == OP_HALT);
  assign is_alu     = !opcode[3] && !is_nop;
  assign is_illegal = opcode[3] && !is_halt;

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/READ/EXEC/WB over an
// imem handshake and an ALU valid/ready handshake. SEQ_RESTART_EN lets start
// leave HALT; without it HALT is absorbing until RST.
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int PC_W = 8,
  parameter int IR_W = 16
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            start,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [IR_W-1:0] imem_data,
  output logic [RA_W-1:0] rf_a1,
  output logic [RA_W-1:0] rf_a2,
  output logic            rf_we,
  output logic [RA_W-1:0] rf_wa,
  output logic [2:0]      alu_op,
  output logic            alu_valid,
  input  logic            alu_ready,
  output logic            busy,
  output logic            halted,
  output logic            illegal,
  output logic [7:0]      retired,
  output state_t          state_dbg
);

  // Handshakes: a request (imem_req / alu_valid) rises with entry to its
  // state and its payload stays constant until the acknowledge (imem_ack /
  // alu_ready) is sampled high on a rising CLK edge; acks elsewhere are ignored.

  state_t            state;
  logic [PC_W-1:0]   pc;
  logic [IR_W-1:0]   ir;
  logic [RA_W-1:0]   d_rd, d_rs1, d_rs2;
  logic [2:0]        d_alu_op;
  logic              d_is_nop, d_is_halt, d_is_alu, d_is_illegal;
  logic              in_window;

  instr_decoder #(.IR_W(IR_W)) u_dec (
    .ir         (ir),
    .rd         (d_rd),
    .rs1        (d_rs1),
    .rs2        (d_rs2),
    .alu_op     (d_alu_op),
    .is_nop     (d_is_nop),
    .is_halt    (d_is_halt),
    .is_alu     (d_is_alu),
    .is_illegal (d_is_illegal)
  );

  assign in_window = (state == DECODE) || (state == READ) ||
                     (state == EXEC)   || (state == WB);
  assign rf_a1     = in_window ? d_rs1 : '0;
  assign rf_a2     = in_window ? d_rs2 : '0;
  assign imem_addr = pc;
  assign state_dbg = state;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      pc        <= '0;
      ir        <= '0;
      retired   <= '0;
      imem_req  <= 1'b0;
      alu_valid <= 1'b0;
      alu_op    <= '0;
      rf_we     <= 1'b0;
      rf_wa     <= '0;
      busy      <= 1'b0;
      halted    <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          pc       <= '0;
          retired  <= '0;
          imem_req <= 1'b1;
          busy     <= 1'b1;
          state    <= FETCH;
        end
        FETCH: if (imem_ack) begin
          ir       <= imem_data;
          imem_req <= 1'b0;
          state    <= DECODE;
        end
        DECODE: begin
          if (d_is_halt) begin
            busy   <= 1'b0;
            halted <= 1'b1;
            state  <= HALT;
          end else if (d_is_alu) begin
            state <= READ;
          end else begin
            // NOP and illegal opcodes both retire without touching the RF.
            illegal  <= illegal | (d_is_illegal & ~d_is_nop);
            pc       <= pc + PC_W'(1);
            retired  <= retired + 8'd1;
            imem_req <= 1'b1;
            state    <= FETCH;
          end
        end
        READ: begin
          alu_valid <= 1'b1;
          alu_op    <= d_alu_op;
          state     <= EXEC;
        end
        EXEC: if (alu_ready) begin
          alu_valid <= 1'b0;
          alu_op    <= '0;
          rf_we     <= 1'b1;
          rf_wa     <= d_rd;
          state     <= WB;
        end
        WB: begin
          rf_we    <= 1'b0;
          rf_wa    <= '0;
          pc       <= pc + PC_W'(1);
          retired  <= retired + 8'd1;
          imem_req <= 1'b1;
          state    <= FETCH;
        end
        HALT: begin
`ifdef SEQ_RESTART_EN
          if (start) begin
            halted   <= 1'b0;
            illegal  <= 1'b0;
            pc       <= '0;
            retired  <= '0;
            imem_req <= 1'b1;
            busy     <= 1'b1;
            state    <= FETCH;
          end
`else
          state <= HALT;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: imem/ALU responders with programmable
// latency, handshake-stability monitor and an rf write-address scoreboard.
module tb_instr_sequencer;
  import seq_pkg::*;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        start = 1'b0;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_data = '0;
  logic [2:0]  rf_a1, rf_a2, rf_wa, alu_op;
  logic        rf_we, alu_valid, busy, halted, illegal;
  logic        alu_ready = 1'b0;
  logic [7:0]  retired;
  state_t      state_dbg;

  instr_sequencer #(.PC_W(8), .IR_W(16)) dut (
    .CLK(CLK), .RST(RST), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .rf_a1(rf_a1), .rf_a2(rf_a2), .rf_we(rf_we), .rf_wa(rf_wa),
    .alu_op(alu_op), .alu_valid(alu_valid), .alu_ready(alu_ready),
    .busy(busy), .halted(halted), .illegal(illegal), .retired(retired),
    .state_dbg(state_dbg)
  );

  // Clock / reset block
  always #5 CLK = ~CLK;

  logic [15:0] mem [0:255];
  logic [2:0]  exp_q[$];
  int          n_asserts = 0;
  int          n_fail = 0;
  int          we_count = 0;
  int          tcount = 0;
  int          ack_delay = 0;
  int          alu_delay = 0;
  int          fetch_wait = 0;
  int          alu_wait = 0;
  logic        prev_req = 0, prev_ack = 0, prev_valid = 0, prev_ready = 0;
  logic [7:0]  prev_addr = '0;
  logic [2:0]  prev_op = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_asserts++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Monitor + responders, all on the falling edge so DUT outputs are settled.
  always @(negedge CLK) begin
    if (RST) begin
      fetch_wait = 0; alu_wait = 0;
      imem_ack = 1'b0; alu_ready = 1'b0;
      prev_req = 0; prev_ack = 0; prev_valid = 0; prev_ready = 0;
    end else begin
      if (prev_req && !prev_ack)
        check("imem_hold", {imem_req, imem_addr}, {1'b1, prev_addr});
      if (prev_valid && !prev_ready)
        check("alu_hold", {alu_valid, alu_op}, {1'b1, prev_op});
      if (prev_ready)
        check("wb_after_ready", rf_we, 1'b1);
      if (rf_we) begin
        we_count++;
        check("rf_we_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) check("rf_wa", rf_wa, exp_q.pop_front());
      end
      imem_ack = 1'b0;
      alu_ready = 1'b0;
      if (imem_req) begin
        if (fetch_wait >= ack_delay) begin
          imem_ack = 1'b1; imem_data = mem[imem_addr]; fetch_wait = 0;
        end else fetch_wait++;
      end
      if (alu_valid) begin
        if (alu_wait >= alu_delay) begin
          alu_ready = 1'b1; alu_wait = 0;
        end else alu_wait++;
      end
      prev_req = imem_req; prev_addr = imem_addr; prev_ack = imem_ack;
      prev_valid = alu_valid; prev_op = alu_op; prev_ready = alu_ready;
    end
  end

  // Driver tasks
  task automatic tick();
    @(negedge CLK);
    tcount++;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    exp_q.delete();
    tick(); tick();
    RST = 1'b0;
    tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_state(input string tag, input state_t s, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (state_dbg == s) break;
      tick();
    end
    check(tag, state_dbg, s);
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {imem_req, imem_addr, rf_a1, rf_a2, rf_we, rf_wa, alu_op, alu_valid,
                busy, halted, illegal, retired}, 64'd0);
    check({tag, "_state"}, state_dbg, IDLE);
  endtask

  initial begin
    int t0, we0;
    clear_mem();

    // Reset state
    tick();
    check_all_zero("reset_outputs");

    // Basic ALU instruction, zero-wait
    do_reset();
    mem[0] = 16'h1298;
    mem[1] = 16'hF000;
    exp_q.push_back(3'd1);
    pulse_start();
    check("c1_fetch", {state_dbg, imem_req, imem_addr, busy}, {FETCH, 1'b1, 8'd0, 1'b1});
    tick();
    check("c2_rf_addr", {state_dbg, rf_a1, rf_a2}, {DECODE, 3'd2, 3'd3});
    tick(); tick();
    check("c4_exec", {state_dbg, alu_valid, alu_op, rf_we}, {EXEC, 1'b1, 3'd1, 1'b0});
    tick();
    check("c5_wb", {rf_we, rf_wa}, {1'b1, 3'd1});
    tick();
    check("c6_next", {rf_we, retired, imem_req, imem_addr}, {1'b0, 8'd1, 1'b1, 8'd1});
    wait_state("basic_halt", HALT, 10);
    check("basic_halt_flags", {halted, busy, imem_req}, {1'b1, 1'b0, 1'b0});

    // Stretched handshakes; a start pulse mid-fetch must be ignored
    do_reset();
    ack_delay = 3; alu_delay = 2;
    mem[0] = 16'h2A50;
    exp_q.push_back(3'd5);
    t0 = tcount;
    pulse_start();
    tick();
    pulse_start();
    wait_state("slow_wb", WB, 30);
    check("slow_wb_cycle", tcount - t0, 10);
    check("slow_wb_addr", {rf_we, rf_wa}, {1'b1, 3'd5});
    wait_state("slow_halt", HALT, 30);
    check("slow_retired", retired, 8'd1);
    ack_delay = 0; alu_delay = 0;

    // NOP, illegal, HALT: no writes, sticky illegal
    clear_mem();
    mem[1] = 16'hA000;
    mem[2] = 16'hF000;
    do_reset();
    we0 = we_count;
    pulse_start();
    wait_state("illegal_halt", HALT, 20);
    check("illegal_flags", {illegal, halted, busy, retired}, {1'b1, 1'b1, 1'b0, 8'd2});
    check("illegal_no_write", we_count - we0, 0);

    // Reset while in EXEC abandons the instruction
    clear_mem();
    mem[0] = 16'h1298;
    alu_delay = 5;
    do_reset();
    exp_q.push_back(3'd1);
    pulse_start();
    wait_state("to_exec", EXEC, 10);
    RST = 1'b1;
    exp_q.delete();
    #1;
    check_all_zero("async_reset");
    we0 = we_count;
    tick(); tick();
    RST = 1'b0;
    repeat (8) tick();
    check("post_reset_idle", {state_dbg, busy}, {IDLE, 1'b0});
    check("post_reset_no_write", we_count - we0, 0);
    alu_delay = 0;

    // pc wrap: 256 NOPs, fetch after address 255 goes to 0
    clear_mem();
    do_reset();
    pulse_start();
    for (int i = 0; i < 700; i++) begin
      if (imem_req && imem_addr == 8'hFF) break;
      tick();
    end
    check("pc_255", {imem_req, imem_addr, retired}, {1'b1, 8'hFF, 8'hFF});
    tick();
    for (int i = 0; i < 5; i++) begin
      if (imem_req) break;
      tick();
    end
    check("pc_wrap", {imem_req, imem_addr, retired}, {1'b1, 8'h00, 8'h00});

    // HALT then start
    clear_mem();
    mem[3] = 16'hF000;
    do_reset();
    pulse_start();
    wait_state("restart_halt", HALT, 20);
    check("restart_pre", {halted, imem_addr, retired}, {1'b1, 8'd3, 8'd3});
    pulse_start();
`ifdef SEQ_RESTART_EN
    check("restart", {state_dbg, halted, busy, imem_req, imem_addr, retired},
          {FETCH, 1'b0, 1'b1, 1'b1, 8'd0, 8'd0});
`else
    check("no_restart", {state_dbg, halted, busy, imem_req, imem_addr, retired},
          {HALT, 1'b1, 1'b0, 1'b0, 8'd3, 8'd3});
`endif
    repeat (4) tick();

    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
